// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone classic arbiter with per-transaction ack watchdog.
// Optional ARB_ROUND_ROBIN_EN selects round-robin instead of M1>M0 priority.
module wb_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_adr,
  input  logic [DATA_W-1:0]   m0_dat_w,
  input  logic [DATA_W/8-1:0] m0_sel,
  output logic [DATA_W-1:0]   m0_dat_r,
  output logic                m0_ack,
  output logic                m0_err,
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_adr,
  input  logic [DATA_W-1:0]   m1_dat_w,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic [DATA_W-1:0]   m1_dat_r,
  output logic                m1_ack,
  output logic                m1_err,
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W-1:0]   s_dat_w,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic [DATA_W-1:0]   s_dat_r,
  input  logic                s_ack
);

  localparam int WD_W = (TIMEOUT_CYCLES < 1) ? 1
                      : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIM =
    WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1,
    ABORT
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic own_cyc;
  logic own_stb;
  logic gnt;
  logic stall;
  logic fire;
  logic pick;

  // Control signals of the currently granted master and watchdog fire.
  always_comb begin
    own_cyc = (state_q == GNT1) ? m1_cyc : m0_cyc;
    own_stb = (state_q == GNT1) ? m1_stb : m0_stb;
    gnt     = (state_q == GNT0) || (state_q == GNT1);
    stall   = gnt && own_cyc && own_stb && !s_ack;
    fire    = WD_EN && stall && (wd_q == WD_LIM);
  end

  // Arbitration winner when in IDLE.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick = (m0_cyc && m1_cyc) ? ~last_q : m1_cyc;
`else
    pick = m1_cyc;
`endif
  end

  // Next-state logic for the grant FSM and the watchdog.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        if (m0_cyc || m1_cyc) begin
          state_d = pick ? GNT1 : GNT0;
          last_d  = pick;
        end
      end
      GNT0, GNT1: begin
        if (!own_cyc) begin
          state_d = IDLE;
          wd_d    = '0;
        end else if (fire) begin
          state_d = ABORT;
          owner_d = (state_q == GNT1);
          wd_d    = '0;
        end else if (s_ack) begin
          wd_d = '0;
        end else if (stall && WD_EN) begin
          wd_d = wd_q + 1'b1;
        end
      end
      ABORT: begin
        if (!(owner_q ? m1_cyc : m0_cyc)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  // Zero-latency bus mux; non-granted side sees all zeros.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_w  = '0;
    s_sel    = '0;
    m0_dat_r = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m1_dat_r = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    if (state_q == GNT0) begin
      s_cyc    = m0_cyc;
      s_stb    = m0_stb;
      s_we     = m0_we;
      s_adr    = m0_adr;
      s_dat_w  = m0_dat_w;
      s_sel    = m0_sel;
      m0_dat_r = s_dat_r;
      m0_ack   = s_ack;
      m0_err   = fire;
    end else if (state_q == GNT1) begin
      s_cyc    = m1_cyc;
      s_stb    = m1_stb;
      s_we     = m1_we;
      s_adr    = m1_adr;
      s_dat_w  = m1_dat_w;
      s_sel    = m1_sel;
      m1_dat_r = s_dat_r;
      m1_ack   = s_ack;
      m1_err   = fire;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter (TIMEOUT_CYCLES=4).
// Acked read data is queued per master and popped on mX_ack.
module tb_wb_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
  logic [3:0]  m0_sel;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
  logic [3:0]  m1_sel;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic [3:0]  s_sel;
  logic        s_ack;

  int n_chk = 0;
  int n_err = 0;
  int errs0 = 0;
  int errs1 = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  bit first;

  always #5 clk = ~clk;

  wb_bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
    .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_sel(m0_sel),
    .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
    .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_sel(m1_sel),
    .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
    .s_dat_r(s_dat_r), .s_ack(s_ack)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit m, input bit cyc, input bit we,
                       input logic [31:0] adr, input logic [31:0] wd);
    if (m) begin
      m1_cyc = cyc; m1_stb = cyc; m1_we = we;
      m1_adr = adr; m1_dat_w = wd; m1_sel = 4'hF;
    end else begin
      m0_cyc = cyc; m0_stb = cyc; m0_we = we;
      m0_adr = adr; m0_dat_w = wd; m0_sel = 4'hF;
    end
  endtask

  task automatic ack(input bit m, input logic [31:0] rd);
    s_ack = 1'b1;
    s_dat_r = rd;
    if (m) q1.push_back(rd);
    else q0.push_back(rd);
    tick();
    s_ack = 1'b0;
    s_dat_r = '0;
  endtask

  // Response monitor: pops expected read data on each forwarded ack.
  always @(negedge clk) begin
    if (!reset) begin
      if (m0_err) errs0++;
      if (m1_err) errs1++;
      if (m0_ack) begin
        if (q0.size() == 0) chk("m0_spur_ack", m0_ack, 0);
        else chk("m0_dat_r", m0_dat_r, q0.pop_front());
        chk("m1_dat_r_idle", m1_dat_r, 0);
      end
      if (m1_ack) begin
        if (q1.size() == 0) chk("m1_spur_ack", m1_ack, 0);
        else chk("m1_dat_r", m1_dat_r, q1.pop_front());
        chk("m0_dat_r_idle", m0_dat_r, 0);
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    s_ack = 1'b0;
    s_dat_r = '0;
    #2;
    chk("rst_s_cyc", {s_cyc, s_stb, s_we}, 0);
    chk("rst_s_bus", {s_adr, s_dat_w}, 0);
    chk("rst_s_sel", s_sel, 0);
    chk("rst_m_resp", {m0_ack, m0_err, m1_ack, m1_err}, 0);
    chk("rst_dat_r", {m0_dat_r, m1_dat_r}, 0);
    tick(); tick();
    reset = 1'b0;

    // single M0 read
    drive(0, 1, 0, 32'h0000_0100, 0);
    #1 chk("t1_idle_s_cyc", s_cyc, 0);
    tick();
    chk("t1_s_cyc", s_cyc, 1);
    chk("t1_s_adr", s_adr, 32'h100);
    chk("t1_s_we_sel", {s_we, s_sel}, 5'h0F);
    tick(); tick();
    ack(0, 32'hDEAD_BEEF);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("t1_back_idle", s_cyc, 0);

    // simultaneous request right after reset (last=1)
    reset = 1'b1;
    tick();
    reset = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    drive(0, 1, 0, 32'h200, 0);
    drive(1, 1, 0, 32'h300, 0);
    tick();
    chk("t2_first_cyc", s_cyc, 1);
    chk("t2_first_adr", s_adr, first ? 32'h300 : 32'h200);
    tick();
    ack(first, 32'h1111_0000);
    drive(first, 0, 0, 0, 0);
    tick();
    chk("t2_gap", s_cyc, 0);
    tick();
    chk("t2_second_cyc", s_cyc, 1);
    chk("t2_second_adr", s_adr, first ? 32'h200 : 32'h300);
    ack(!first, 32'h2222_0000);
    drive(!first, 0, 0, 0, 0);
    tick(); tick();

    // M1 holds cyc over 3 stores while M0 waits
    drive(1, 1, 1, 32'h400, 32'hA0);
    tick();
    drive(0, 1, 0, 32'h500, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 32'h400 + 4 * i, 32'hA0 + i);
      #1;
      chk("t3_adr", s_adr, 32'h400 + 4 * i);
      chk("t3_we", s_we, 1);
      chk("t3_dat_w", s_dat_w, 32'hA0 + i);
      ack(1, 32'h5A5A_0000 + i);
    end
    drive(1, 0, 0, 0, 0);
    tick();
    chk("t3_gap", s_cyc, 0);
    tick();
    chk("t3_m0_adr", s_adr, 32'h500);
    ack(0, 32'h00C0_FFEE);
    drive(0, 0, 0, 0, 0);
    tick(); tick();

    // M1 stalls until the watchdog aborts it
    drive(1, 1, 0, 32'h600, 0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk("t4_err", m1_err, (i == 4) ? 1 : 0);
      tick();
    end
    chk("t4_abort_s_cyc", s_cyc, 0);
    chk("t4_err_off", m1_err, 0);
    s_ack = 1'b1;
    s_dat_r = 32'hBAD0_BAD0;
    tick(); tick();
    s_ack = 1'b0;
    chk("t4_abort_hold", s_cyc, 0);
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 32'h700, 0);
    tick();
    chk("t4_m0_cyc", s_cyc, 1);
    chk("t4_m0_adr", s_adr, 32'h700);
    ack(0, 32'h1234_5678);
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    chk("t4_err_pulses", errs1, 1);

    // ack lands on the watchdog-limit cycle
    drive(1, 1, 0, 32'h800, 0);
    repeat (4) tick();
    s_ack = 1'b1;
    s_dat_r = 32'h0000_55AA;
    q1.push_back(32'h0000_55AA);
    #1;
    chk("t5_err", m1_err, 0);
    chk("t5_ack", m1_ack, 1);
    tick();
    s_ack = 1'b0;
    chk("t5_no_abort", s_cyc, 1);
    drive(1, 1, 0, 32'h804, 0);
    repeat (3) tick();
    ack(1, 32'h0000_66BB);
    chk("t5_still_gnt", s_cyc, 1);
    drive(1, 0, 0, 0, 0);
    tick(); tick();
    chk("t5_err_pulses", errs1, 1);

    // reset while M0 waits for ack
    drive(0, 1, 0, 32'h900, 0);
    tick(); tick();
    chk("t6_pre", s_cyc, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_async", s_cyc, 0);
    chk("t6_no_resp", {m0_ack, m0_err}, 0);
    drive(0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    s_ack = 1'b1;
    s_dat_r = 32'hFFFF_FFFF;
    #1;
    chk("t6_spur", {m0_ack, m1_ack}, 0);
    tick(); tick();
    s_ack = 1'b0;
    chk("t6_idle", s_cyc, 0);

    chk("q_empty", q0.size() + q1.size(), 0);
    chk("m0_err_pulses", errs0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
